// File: rtl/seq_frame_tx.sv
// seq_frame_tx -- serial frame transmitter.
//
// Serializes one payload word per frame onto a single-bit line. A frame is
// the SYNC_SEQ pattern (MSB first), the payload (MSB first), then GAP_BITS
// idle bits. A new word can be accepted on the last bit of the current frame,
// so back-to-back traffic yields a continuous stream with no extra idle bit.
//
// State | Meaning
// IDLE    | line at IDLE_BIT, ready for a word
// SYNC    | sync pattern bit on the line
// PAYLOAD | payload bit on the line
// GAP     | idle gap bit after the payload
//
// Ports:
//   clk          clock
//   rst          asynchronous active-high reset
//   data_in      payload word, captured on the accept edge
//   data_valid   payload available
//   data_ready   word can be accepted on this edge
//   out_stream   registered serial line
//   frame_active sync or payload bit on the line
//   sync_active  sync bit on the line
//   payload_last last payload bit on the line
module seq_frame_tx #(
    parameter int unsigned           SEQ_WIDTH  = 4,
    parameter logic [SEQ_WIDTH-1:0]  SYNC_SEQ   = 4'b1001,
    parameter int unsigned           DATA_WIDTH = 8,
    parameter int unsigned           GAP_BITS   = 2,
    parameter logic                  IDLE_BIT   = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    output logic                  data_ready,
    output logic                  out_stream,
    output logic                  frame_active,
    output logic                  sync_active,
    output logic                  payload_last
);

    localparam int unsigned FRAME_W  = SEQ_WIDTH + DATA_WIDTH;
    localparam int unsigned MAX_SD   = (SEQ_WIDTH > DATA_WIDTH) ? SEQ_WIDTH : DATA_WIDTH;
    localparam int unsigned CNT_MAX  = (MAX_SD > GAP_BITS) ? MAX_SD : GAP_BITS;
    localparam int unsigned CW       = $clog2(CNT_MAX);
    localparam int unsigned GAP_LOAD = (GAP_BITS > 0) ? GAP_BITS - 1 : 0;

    typedef enum logic [1:0] {IDLE, SYNC, PAYLOAD, GAP} state_t;

    state_t               state;
    logic [CW-1:0]        cnt;       // bits remaining in the current state, minus one
    logic [FRAME_W-1:0]   frame_sr;  // bits still to send: rest of sync, then payload
    logic                 last_bit;
    logic                 accept;

    always_comb begin
        last_bit = 1'b0;
        if (GAP_BITS == 0)
            last_bit = (state == PAYLOAD) && (cnt == '0);
        else
            last_bit = (state == GAP) && (cnt == '0);
    end

    assign data_ready = (state == IDLE) || last_bit;
    assign accept     = data_valid && data_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            frame_sr     <= '0;
            out_stream   <= IDLE_BIT;
            frame_active <= 1'b0;
            sync_active  <= 1'b0;
            payload_last <= 1'b0;
        end else if (accept) begin
            // The first sync bit goes straight onto the line; the remaining
            // sync bits and the payload queue up behind it in one shifter.
            state        <= SYNC;
            cnt          <= CW'(SEQ_WIDTH - 1);
            frame_sr     <= {SYNC_SEQ[SEQ_WIDTH-2:0], data_in, 1'b0};
            out_stream   <= SYNC_SEQ[SEQ_WIDTH-1];
            frame_active <= 1'b1;
            sync_active  <= 1'b1;
            payload_last <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    out_stream   <= IDLE_BIT;
                    frame_active <= 1'b0;
                    sync_active  <= 1'b0;
                    payload_last <= 1'b0;
                end
                SYNC: begin
                    out_stream <= frame_sr[FRAME_W-1];
                    frame_sr   <= frame_sr << 1;
                    if (cnt == '0) begin
                        state        <= PAYLOAD;
                        cnt          <= CW'(DATA_WIDTH - 1);
                        sync_active  <= 1'b0;
                        payload_last <= (DATA_WIDTH == 1);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                PAYLOAD: begin
                    if (cnt != '0) begin
                        out_stream   <= frame_sr[FRAME_W-1];
                        frame_sr     <= frame_sr << 1;
                        cnt          <= cnt - 1'b1;
                        payload_last <= (cnt == CW'(1));
                    end else begin
                        out_stream   <= IDLE_BIT;
                        frame_active <= 1'b0;
                        payload_last <= 1'b0;
                        if (GAP_BITS == 0) begin
                            state <= IDLE;
                        end else begin
                            state <= GAP;
                            cnt   <= CW'(GAP_LOAD);
                        end
                    end
                end
                GAP: begin
                    out_stream <= IDLE_BIT;
                    if (cnt == '0)
                        state <= IDLE;
                    else
                        cnt <= cnt - 1'b1;
                end
                default: begin
                    state      <= IDLE;
                    out_stream <= IDLE_BIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_frame_tx.sv
// Testbench for seq_frame_tx. Two instances share the input stimulus: one at
// default parameters (GAP_BITS=2) and one with GAP_BITS=0. Each instance has
// its own position-in-frame reference model; directed steps add literal
// expected line patterns on top of the model comparisons.
module tb_seq_frame_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic       data_valid;

    logic ready_a, out_a, fa_a, sa_a, pl_a;
    logic ready_b, out_b, fa_b, sa_b, pl_b;

    always #5 clk = ~clk;

    seq_frame_tx u_dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
        .data_ready(ready_a), .out_stream(out_a), .frame_active(fa_a),
        .sync_active(sa_a), .payload_last(pl_a)
    );

    seq_frame_tx #(.GAP_BITS(0)) u_dut0 (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
        .data_ready(ready_b), .out_stream(out_b), .frame_active(fa_b),
        .sync_active(sa_b), .payload_last(pl_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: pos = 0 when idle, else 1..frame length (bit index on line).
    int         pos[2];
    logic [7:0] pay[2];
    int         gap[2] = '{2, 0};
    logic [3:0] sync_v = 4'b1001;

    function automatic int flen(int k);
        return 4 + 8 + gap[k];
    endfunction

    function automatic logic m_out(int k);
        if (pos[k] >= 1 && pos[k] <= 4)  return sync_v[4 - pos[k]];
        if (pos[k] >= 5 && pos[k] <= 12) return pay[k][12 - pos[k]];
        return 1'b0;
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_dut(input int k, input logic o, input logic r,
                             input logic f, input logic s, input logic p);
        check($sformatf("out[%0d] pos%0d", k, pos[k]), o, m_out(k));
        check($sformatf("ready[%0d] pos%0d", k, pos[k]), r, (pos[k] == 0) || (pos[k] == flen(k)));
        check($sformatf("frame_active[%0d] pos%0d", k, pos[k]), f, (pos[k] >= 1) && (pos[k] <= 12));
        check($sformatf("sync_active[%0d] pos%0d", k, pos[k]), s, (pos[k] >= 1) && (pos[k] <= 4));
        check($sformatf("payload_last[%0d] pos%0d", k, pos[k]), p, pos[k] == 12);
    endtask

    task automatic check_both();
        check_dut(0, out_a, ready_a, fa_a, sa_a, pl_a);
        check_dut(1, out_b, ready_b, fa_b, sa_b, pl_b);
    endtask

    // One clock edge: model advances using pre-edge inputs, then both DUTs are checked.
    task automatic tick();
        logic acc [2];
        for (int k = 0; k < 2; k++)
            acc[k] = data_valid && ((pos[k] == 0) || (pos[k] == flen(k)));
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (acc[k]) begin
                pos[k] = 1;
                pay[k] = data_in;
            end else if (pos[k] != 0) begin
                pos[k] = (pos[k] == flen(k)) ? 0 : pos[k] + 1;
            end
        end
        #1;
        check_both();
    endtask

    initial begin
        logic [13:0] line14;
        logic [27:0] line28;
        logic [3:0]  window;
        int          hits;

        pos[0] = 0; pos[1] = 0;
        pay[0] = '0; pay[1] = '0;
        rst = 1'b1; data_valid = 1'b0; data_in = 8'h00;

        // Reset state
        #12;
        check_both();
        @(negedge clk) rst = 1'b0;
        tick();

        // Single frame 8'hA5 with literal expected line
        line14 = 14'b1001_10100101_00;
        data_valid = 1'b1; data_in = 8'hA5;
        tick();
        data_valid = 1'b0; data_in = 8'($urandom);
        for (int c = 1; c <= 14; c++) begin
            check($sformatf("a5_out c%0d", c), out_a, line14[14 - c]);
            check($sformatf("a5_sync c%0d", c), sa_a, c <= 4);
            check($sformatf("a5_frame c%0d", c), fa_a, c <= 12);
            check($sformatf("a5_plast c%0d", c), pl_a, c == 12);
            check($sformatf("a5_ready c%0d", c), ready_a, c == 14);
            if (c == 12) begin
                check("gap0_ready c12", ready_b, 1'b1);
                check("gap0_plast c12", pl_b, 1'b1);
            end
            tick();
        end
        repeat (2) tick();

        // Back-to-back A5 then 3C with valid held high
        line28 = 28'b1001_10100101_00_1001_00111100_00;
        data_valid = 1'b1; data_in = 8'hA5;
        tick();
        data_in = 8'h3C;
        for (int c = 1; c <= 28; c++) begin
            if (c == 15) data_valid = 1'b0;
            check($sformatf("b2b_out c%0d", c), out_a, line28[28 - c]);
            if (c == 15) check("b2b_sync_start c15", sa_a, 1'b1);
            if (c == 13) begin
                check("gap0_sync2 c13", sa_b, 1'b1);
                check("gap0_out2 c13", out_b, 1'b1);
            end
            tick();
        end
        repeat (3) tick();

        // Loopback with an overlapping 1001 detector, payload 8'h00
        data_valid = 1'b1; data_in = 8'h00;
        window = 4'b0000;
        hits = 0;
        tick();
        data_valid = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            window = {window[2:0], out_a};
            if (window == 4'b1001) begin
                hits++;
                check($sformatf("det_hit_at_sync_end c%0d", c), c == 4, 1'b1);
            end
            tick();
        end
        check("det_hits_per_frame", hits == 1, 1'b1);
        repeat (2) tick();

        // Reset during cycle 7 of an 8'hFF frame
        data_valid = 1'b1; data_in = 8'hFF;
        tick();
        data_valid = 1'b0;
        repeat (6) tick();
        #3 rst = 1'b1;
        #1;
        pos[0] = 0; pos[1] = 0;
        check("rst_out", out_a, 1'b0);
        check("rst_ready", ready_a, 1'b1);
        check("rst_frame", fa_a, 1'b0);
        check("rst_sync", sa_a, 1'b0);
        check("rst_plast", pl_a, 1'b0);
        check_both();
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        tick();
        data_valid = 1'b1; data_in = 8'h5A;
        tick();
        data_valid = 1'b0;
        line14 = 14'b1001_01011010_00;
        for (int c = 1; c <= 14; c++) begin
            check($sformatf("post_rst_out c%0d", c), out_a, line14[14 - c]);
            tick();
        end

        // Valid pulses while a frame is in flight are ignored
        data_valid = 1'b1; data_in = 8'hC3;
        tick();
        data_valid = 1'b0;
        line14 = 14'b1001_11000011_00;
        for (int c = 1; c <= 14; c++) begin
            if (c >= 3 && c <= 10) begin
                data_valid = 1'($urandom_range(0, 1));
                data_in    = 8'($urandom);
            end else begin
                data_valid = 1'b0;
            end
            check($sformatf("hold_out c%0d", c), out_a, line14[14 - c]);
            tick();
        end
        data_valid = 1'b0;
        repeat (3) tick();

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            data_valid = ($urandom_range(0, 2) != 0);
            data_in    = 8'($urandom);
            tick();
        end
        data_valid = 1'b0;
        repeat (20) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
